// File: rtl/demux5_16_if.sv
// Bundle for the 1-to-5 word distributor: one upstream source port and five
// downstream sink channels, each using valid/ready.
interface demux5_16_if #(
  parameter int WIDTH = 16
);
  // Handshake rule on every port: a word moves on a rising clock edge exactly
  // when valid and ready are both high. The producer holds its data and
  // valid stable until that edge. The consumer may raise ready without
  // waiting for valid.
  logic [WIDTH-1:0] Din;
  logic [2:0]       select;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] Dout0, Dout1, Dout2, Dout3, Dout4;
  logic             valid0, valid1, valid2, valid3, valid4;
  logic             ready0, ready1, ready2, ready3, ready4;

  // Distributor side
  modport slave (
    input  Din, select, in_valid,
    output in_ready,
    output Dout0, Dout1, Dout2, Dout3, Dout4,
    output valid0, valid1, valid2, valid3, valid4,
    input  ready0, ready1, ready2, ready3, ready4
  );

  // Environment side: the source and the five sinks
  modport master (
    output Din, select, in_valid,
    input  in_ready,
    input  Dout0, Dout1, Dout2, Dout3, Dout4,
    input  valid0, valid1, valid2, valid3, valid4,
    output ready0, ready1, ready2, ready3, ready4
  );
endinterface

// File: rtl/demux5_16.sv
// Registered 1-to-5 demultiplexer with a single-entry holding register.
// A held word drains to its channel and a new word can load on the same edge.
module demux5_16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  demux5_16_if.slave       io,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [2:0] {
    CH0 = 3'd0,
    CH1 = 3'd1,
    CH2 = 3'd2,
    CH3 = 3'd3,
    CH4 = 3'd4
  } dest_e;

  logic [WIDTH-1:0] data_q, data_d;
  dest_e            dest_q, dest_d;
  logic             full_q, full_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic sel_ready;
  logic accept;
  logic drain;

  // Codes 100..111 all fall into the default channel 4.
  function automatic dest_e decode(input logic [2:0] sel);
    dest_e ch;
    case (sel)
      3'b000:  ch = CH0;
      3'b001:  ch = CH1;
      3'b010:  ch = CH2;
      3'b011:  ch = CH3;
      default: ch = CH4;
    endcase
    return ch;
  endfunction

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      data_q <= '0;
      dest_q <= CH0;
      full_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      dest_q <= dest_d;
      full_q <= full_d;
      cnt_q  <= cnt_d;
    end
  end

  // Only the ready of the channel currently being addressed matters.
  always_comb begin
    sel_ready = 1'b0;
    case (dest_q)
      CH0:     sel_ready = io.ready0;
      CH1:     sel_ready = io.ready1;
      CH2:     sel_ready = io.ready2;
      CH3:     sel_ready = io.ready3;
      default: sel_ready = io.ready4;
    endcase
  end

  assign drain  = full_q && sel_ready;
  assign accept = io.in_valid && io.in_ready;

  // Next-state logic
  always_comb begin
    data_d = data_q;
    dest_d = dest_q;
    full_d = full_q;
    cnt_d  = cnt_q;
    if (accept) begin
      data_d = io.Din;
      dest_d = decode(io.select);
      full_d = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end
    if (drain) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output logic: everything below depends only on state and the sink readies.
  always_comb begin
    io.in_ready = !full_q || sel_ready;
    io.valid0   = full_q && (dest_q == CH0);
    io.valid1   = full_q && (dest_q == CH1);
    io.valid2   = full_q && (dest_q == CH2);
    io.valid3   = full_q && (dest_q == CH3);
    io.valid4   = full_q && (dest_q == CH4);
    io.Dout0    = io.valid0 ? data_q : '0;
    io.Dout1    = io.valid1 ? data_q : '0;
    io.Dout2    = io.valid2 ? data_q : '0;
    io.Dout3    = io.valid3 ? data_q : '0;
    io.Dout4    = io.valid4 ? data_q : '0;
    busy        = full_q;
    xfer_count  = cnt_q;
  end

endmodule

// File: doc/demux5_16.md
Name: demux5_16

Overview:
- Registered 1-to-5 demultiplexer. It is the distribution counterpart of the 5:1 16-bit source mux.
- Takes one 16-bit word stream with a 3-bit destination select and delivers each word to exactly one of five sink channels.
- Uses a valid/ready handshake on both sides and a single-entry holding register, so a stalled sink back-pressures the source without losing data.
- Sits between the final-project datapath producer and five consumer blocks (register/memory/peripheral write ports).

Parameters:
- WIDTH, 16, data width of Din and every DoutN.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Din  input  WIDTH  word to distribute.
- select  input  3  destination code, sampled with Din.
- in_valid  input  1  source presents Din/select this cycle.
- in_ready  output  1  block can accept Din this cycle.
- Dout0..Dout4  output  WIDTH each  per-channel data.
- valid0..valid4  output  1 each  per-channel word-available.
- ready0..ready4  input  1 each  per-channel sink accepts.
- busy  output  1  holding register occupied.
- xfer_count  output  CNT_W  total words delivered to any sink since reset.

Behaviour:
- Destination decode, applied at accept time:
  - 3'b000 -> ch0, 3'b001 -> ch1, 3'b010 -> ch2, 3'b011 -> ch3.
  - 3'b100..3'b111 -> ch4 (default channel).
- State: data_q[WIDTH], dest_q (ch0..ch4), full_q, cnt_q[CNT_W].
- Reset (Reset_n=0, asynchronous, immediate):
  - data_q=0, dest_q=ch0, full_q=0, cnt_q=0.
  - Therefore all validN=0, all DoutN=0, busy=0, xfer_count=0.
  - in_ready=1 once Reset_n is high.
  - A word held when reset asserts is discarded; the source must resend it.
- Handshake signals (combinational from state, no input-to-output data path):
  - in_ready = !full_q || ready[dest_q].
  - accept = in_valid && in_ready.
  - drain = full_q && ready[dest_q].
- Output drive:
  - validN = full_q && (dest_q==N).
  - DoutN = data_q when validN, else 0.
  - busy = full_q. xfer_count = cnt_q.
- Register updates per cycle:
  - accept: data_q<=Din, dest_q<=decode(select), full_q<=1.
  - drain && !accept: full_q<=0. data_q and dest_q hold their last values; outputs are still gated by full_q.
  - drain (with or without accept): cnt_q<=cnt_q+1, wrapping modulo 2^CNT_W.
  - Simultaneous drain and accept (pass-through): the new word replaces the old in the same edge and full_q stays 1. Sustained throughput is 1 word/cycle.
- Latency: a word accepted at edge k appears on its channel (validN=1) in the cycle after edge k. It is delivered at the first edge where readyN=1.
- Back-pressure:
  - While full_q && !ready[dest_q]: in_ready=0, data_q and dest_q are stable, validN is held high.
  - in_valid is ignored while in_ready=0; no word is dropped or duplicated.
- readyM for M != dest_q has no effect. Sinks must not depend on valid before asserting ready (no combinational loop).
- in_valid=0: no state change except a possible drain.
- select is don't-care when in_valid=0.

Test Plan:
1. Reset: hold Reset_n=0 with in_valid=1, select=3'b001, Din=16'h1111 -> all validN=0, DoutN=16'h0000, busy=0, xfer_count=0. After release, in_ready=1.
2. Single route: select=3'b010, Din=16'hBEEF, in_valid for 1 cycle, ready2=1 -> next cycle valid2=1 and Dout2=16'hBEEF, other channels valid=0 and Dout=0. After the following edge busy=0 and xfer_count=1.
3. Default decode: select=3'b110, Din=16'h1234 -> valid4=1, Dout4=16'h1234, valid0..3=0.
4. Back-pressure: ready1=0; send 16'hAAAA (select 001), then present 16'h5555 (select 000) -> in_ready=0 and Dout1 stays 16'hAAAA for 5 cycles. Raise ready1 -> AAAA delivers and 5555 is accepted on the same edge. Next cycle valid0=1, Dout0=16'h5555.
5. Streaming: 5 consecutive words 16'h0001..16'h0005 to selects 000..100, all readyN=1 -> in_ready stays 1, each channel pulses valid for exactly one cycle in order, xfer_count=5.
6. Reset mid-hold and wrap:
   - Word held with ready3=0, then pulse Reset_n low between edges -> valid3 drops immediately, count=0.
   - Separately, 65536 streamed deliveries -> xfer_count wraps to 0.
